// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types, opcodes and a_user default shared by TL-UL hosts
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: 4'h9,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic                  a_valid;
    tl_a_op_e              a_opcode;
    logic [2:0]            a_param;
    logic [TL_SZW-1:0]     a_size;
    logic [TL_AIW-1:0]     a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DBW-1:0]     a_mask;
    logic [TL_DW-1:0]      a_data;
    tl_a_user_t            a_user;
    logic                  d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                  d_valid;
    tl_d_op_e              d_opcode;
    logic [2:0]            d_param;
    logic [TL_SZW-1:0]     d_size;
    logic [TL_AIW-1:0]     d_source;
    logic [TL_DIW-1:0]     d_sink;
    logic [TL_DW-1:0]      d_data;
    logic                  d_error;
    logic                  a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_data_host.sv
// rtl/tlul_data_host.sv - core load/store port to TL-UL host adapter
// One-entry registered A channel, in-order D responses checked against an expected source.
module tlul_data_host
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int SrcW           = $clog2(MaxOutstanding)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);

  localparam logic [SrcW:0] MaxOutst = MaxOutstanding[SrcW:0];

  logic            buf_valid_q, buf_valid_d;
  tl_a_op_e        buf_opcode_q, buf_opcode_d;
  logic [29:0]     buf_addr_q, buf_addr_d;
  logic [3:0]      buf_mask_q, buf_mask_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [SrcW-1:0] buf_source_q, buf_source_d;
  logic [SrcW-1:0] issue_ptr_q, issue_ptr_d;
  logic [SrcW-1:0] expect_ptr_q, expect_ptr_d;
  logic [SrcW:0]   outst_q, outst_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic gnt;
  logic d_fire;
  logic stray;
  logic d_accept;
  logic unused_tl;

  assign unused_tl = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink,
                       tl_h_i.d_source[TL_AIW-1:SrcW], data_addr_i[1:0]};

  assign gnt      = data_req_i && (!buf_valid_q || tl_h_i.a_ready) && (outst_q < MaxOutst);
  // d_ready is tied high, so every d_valid is a completed beat
  assign d_fire   = tl_h_i.d_valid;
  assign stray    = d_fire && (outst_q == '0);
  assign d_accept = d_fire && !stray;

  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_opcode_d = buf_opcode_q;
    buf_addr_d   = buf_addr_q;
    buf_mask_d   = buf_mask_q;
    buf_data_d   = buf_data_q;
    buf_source_d = buf_source_q;
    issue_ptr_d  = issue_ptr_q;
    if (gnt) begin
      buf_valid_d  = 1'b1;
      buf_addr_d   = data_addr_i[31:2];
      buf_source_d = issue_ptr_q;
      issue_ptr_d  = issue_ptr_q + 1'b1;
      if (data_we_i) begin
        buf_opcode_d = (data_be_i == 4'hF) ? PutFullData : PutPartialData;
        buf_mask_d   = data_be_i;
        buf_data_d   = data_wdata_i;
      end else begin
        buf_opcode_d = Get;
        buf_mask_d   = 4'hF;
        buf_data_d   = 32'h0;
      end
    end else if (buf_valid_q && tl_h_i.a_ready) begin
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    outst_d      = outst_q;
    expect_ptr_d = expect_ptr_q;
    unique case ({gnt, d_accept})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    if (d_accept) begin
      expect_ptr_d = expect_ptr_q + 1'b1;
    end
    rvalid_d = d_fire;
    rdata_d  = (d_fire && tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : 32'h0;
    err_d    = d_fire && (tl_h_i.d_error || stray ||
                          (tl_h_i.d_source[SrcW-1:0] != expect_ptr_q));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_valid_q  <= 1'b0;
      buf_opcode_q <= PutFullData;
      buf_addr_q   <= '0;
      buf_mask_q   <= '0;
      buf_data_q   <= '0;
      buf_source_q <= '0;
      issue_ptr_q  <= '0;
      expect_ptr_q <= '0;
      outst_q      <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_opcode_q <= buf_opcode_d;
      buf_addr_q   <= buf_addr_d;
      buf_mask_q   <= buf_mask_d;
      buf_data_q   <= buf_data_d;
      buf_source_q <= buf_source_d;
      issue_ptr_q  <= issue_ptr_d;
      expect_ptr_q <= expect_ptr_d;
      outst_q      <= outst_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = buf_valid_q;
    tl_h_o.a_opcode  = buf_opcode_q;
    tl_h_o.a_param   = 3'h0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = {{(TL_AIW-SrcW){1'b0}}, buf_source_q};
    tl_h_o.a_address = {buf_addr_q, 2'b00};
    tl_h_o.a_mask    = buf_mask_q;
    tl_h_o.a_data    = buf_data_q;
    tl_h_o.a_user    = TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = 1'b1;
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_tlul_data_host.sv
// tb/tb_tlul_data_host.sv - directed self-checking bench for tlul_data_host
module tb_tlul_data_host;
  import tlul_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tlul_data_host dut (
    .clock         (clock),
    .reset         (reset),
    .data_req_i    (data_req),
    .data_we_i     (data_we),
    .data_be_i     (data_be),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_gnt_o    (data_gnt),
    .data_rvalid_o (data_rvalid),
    .data_rdata_o  (data_rdata),
    .data_err_o    (data_err),
    .tl_h_o        (tl_h),
    .tl_h_i        (tl_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Present a request at a negedge, check the combinational grant, then advance one cycle.
  task automatic issue(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic exp_gnt);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
    #1;
    check({tag, "_gnt"}, 32'(data_gnt), 32'(exp_gnt));
    tick();
    data_req = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [7:0] src);
    check({tag, "_avalid"}, 32'(tl_h.a_valid), 32'd1);
    check({tag, "_op"},     32'(tl_h.a_opcode), 32'(op));
    check({tag, "_addr"},   tl_h.a_address, addr);
    check({tag, "_mask"},   32'(tl_h.a_mask), 32'(mask));
    check({tag, "_src"},    32'(tl_h.a_source), 32'(src));
  endtask

  task automatic d_beat(input string tag, input tl_d_op_e op, input logic [31:0] data,
                        input logic [7:0] src, input logic derr,
                        input logic [31:0] exp_rdata, input logic exp_err);
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = op;
    tl_d.d_data   = data;
    tl_d.d_source = src;
    tl_d.d_error  = derr;
    tick();
    tl_d.d_valid = 1'b0;
    tl_d.d_error = 1'b0;
    #1;
    check({tag, "_rvalid"}, 32'(data_rvalid), 32'd1);
    check({tag, "_rdata"},  data_rdata, exp_rdata);
    check({tag, "_err"},    32'(data_err), 32'(exp_err));
  endtask

  initial begin
    tl_d         = '0;
    tl_d.a_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_avalid", 32'(tl_h.a_valid), 32'd0);
    check("rst_dready", 32'(tl_h.d_ready), 32'd1);
    check("rst_gnt",    32'(data_gnt), 32'd0);
    check("rst_rvalid", 32'(data_rvalid), 32'd0);
    check("rst_rdata",  data_rdata, 32'd0);
    check("rst_err",    32'(data_err), 32'd0);
    reset = 1'b1;
    tick();

    // 1: single load
    issue("t1", 1'b0, 4'h0, 32'h104, 32'h0, 1'b1);
    check_a("t1", 3'h4, 32'h104, 4'hF, 8'd0);
    check("t1_size", 32'(tl_h.a_size), 32'd2);
    tick();
    check("t1_drain", 32'(tl_h.a_valid), 32'd0);
    d_beat("t1", AccessAckData, 32'hDEADBEEF, 8'd0, 1'b0, 32'hDEADBEEF, 1'b0);
    tick();
    check("t1_pulse", 32'(data_rvalid), 32'd0);

    // 2: partial, full and empty-mask stores
    issue("t2a", 1'b1, 4'h3, 32'h10A, 32'h1234, 1'b1);
    check_a("t2a", 3'h1, 32'h108, 4'h3, 8'd1);
    check("t2a_data", tl_h.a_data, 32'h1234);
    d_beat("t2a", AccessAck, 32'hFFFF_FFFF, 8'd1, 1'b0, 32'h0, 1'b0);
    issue("t2b", 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 1'b1);
    check_a("t2b", 3'h0, 32'h20, 4'hF, 8'd2);
    d_beat("t2b", AccessAck, 32'h0, 8'd2, 1'b0, 32'h0, 1'b0);
    issue("t2c", 1'b1, 4'h0, 32'h24, 32'h5, 1'b1);
    check_a("t2c", 3'h1, 32'h24, 4'h0, 8'd3);
    d_beat("t2c", AccessAck, 32'h0, 8'd3, 1'b0, 32'h0, 1'b0);

    // 3: six back-to-back loads, D withheld, then one response frees one slot
    data_req = 1'b1;
    data_we  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data_addr = 32'h200 + 32'(4 * k);
      #1;
      check($sformatf("t3_gnt%0d", k), 32'(data_gnt), 32'(k < 4));
      if (k >= 1 && k <= 4)
        check($sformatf("t3_src%0d", k), 32'(tl_h.a_source), 32'(k - 1));
      tick();
    end
    check("t3_idle", 32'(tl_h.a_valid), 32'd0);
    tl_d.d_valid  = 1'b1;
    tl_d.d_opcode = AccessAckData;
    tl_d.d_data   = 32'h11;
    tl_d.d_source = 8'd0;
    #1;
    check("t3_full_gnt", 32'(data_gnt), 32'd0);
    tick();
    tl_d.d_valid = 1'b0;
    #1;
    check("t3_rvalid", 32'(data_rvalid), 32'd1);
    check("t3_err",    32'(data_err), 32'd0);
    check("t3_regnt",  32'(data_gnt), 32'd1);
    tick();
    check_a("t3_wrap", 3'h4, 32'h214, 4'hF, 8'd0);
    #1;
    check("t3_full2_gnt", 32'(data_gnt), 32'd0);
    data_req = 1'b0;
    tick();
    d_beat("t3_d1", AccessAckData, 32'h1, 8'd1, 1'b0, 32'h1, 1'b0);
    d_beat("t3_d2", AccessAckData, 32'h2, 8'd2, 1'b0, 32'h2, 1'b0);
    d_beat("t3_d3", AccessAckData, 32'h3, 8'd3, 1'b0, 32'h3, 1'b0);
    d_beat("t3_d0", AccessAckData, 32'h4, 8'd0, 1'b0, 32'h4, 1'b0);

    // 4: a_ready back-pressure
    tl_d.a_ready = 1'b0;
    issue("t4", 1'b0, 4'h0, 32'h300, 32'h0, 1'b1);
    data_req  = 1'b1;
    data_addr = 32'h400;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t4_hold_gnt%0d", k), 32'(data_gnt), 32'd0);
      check($sformatf("t4_hold_addr%0d", k), tl_h.a_address, 32'h300);
      check($sformatf("t4_hold_src%0d", k), 32'(tl_h.a_source), 32'd1);
      tick();
    end
    tl_d.a_ready = 1'b1;
    #1;
    check("t4_release_gnt", 32'(data_gnt), 32'd1);
    tick();
    data_req = 1'b0;
    check_a("t4_next", 3'h4, 32'h400, 4'hF, 8'd2);
    tick();
    d_beat("t4_d1", AccessAckData, 32'h7, 8'd1, 1'b0, 32'h7, 1'b0);
    d_beat("t4_d2", AccessAckData, 32'h8, 8'd2, 1'b0, 32'h8, 1'b0);

    // 5: error responses
    issue("t5a", 1'b0, 4'h0, 32'h500, 32'h0, 1'b1);
    d_beat("t5_derr", AccessAckData, 32'h9, 8'd3, 1'b1, 32'h9, 1'b1);
    d_beat("t5_stray", AccessAck, 32'h0, 8'd0, 1'b0, 32'h0, 1'b1);
    issue("t5b", 1'b0, 4'h0, 32'h504, 32'h0, 1'b1);
    check_a("t5b", 3'h4, 32'h504, 4'hF, 8'd0);
    d_beat("t5_srcmm", AccessAckData, 32'hA, 8'd2, 1'b0, 32'hA, 1'b1);
    issue("t5c", 1'b0, 4'h0, 32'h508, 32'h0, 1'b1);
    d_beat("t5_ok", AccessAckData, 32'hB, 8'd1, 1'b0, 32'hB, 1'b0);
    for (int k = 0; k < 5; k++)
      issue($sformatf("t5_fill%0d", k), 1'b0, 4'h0, 32'h600, 32'h0, k < 4);

    // 6: asynchronous reset with transactions in flight
    d_beat("t6_d2", AccessAckData, 32'hC, 8'd2, 1'b0, 32'hC, 1'b0);
    d_beat("t6_d3", AccessAckData, 32'hD, 8'd3, 1'b0, 32'hD, 1'b0);
    issue("t6a", 1'b0, 4'h0, 32'h700, 32'h0, 1'b1);
    check("t6_pre_avalid", 32'(tl_h.a_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_avalid",  32'(tl_h.a_valid), 32'd0);
    check("t6_dready",  32'(tl_h.d_ready), 32'd1);
    check("t6_gnt",     32'(data_gnt), 32'd0);
    check("t6_rvalid",  32'(data_rvalid), 32'd0);
    check("t6_rdata",   data_rdata, 32'd0);
    check("t6_err",     32'(data_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    d_beat("t6_stale", AccessAckData, 32'hE, 8'd0, 1'b0, 32'hE, 1'b1);
    issue("t6b", 1'b0, 4'h0, 32'h800, 32'h0, 1'b1);
    check_a("t6b", 3'h4, 32'h800, 4'hF, 8'd0);
    for (int k = 0; k < 4; k++)
      issue($sformatf("t6_fill%0d", k), 1'b0, 4'h0, 32'h804, 32'h0, k < 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
